// File: rtl/db_read_sequencer.sv
// Read-side sequencer for the double-buffered memory core: issues credit-limited reads per frame,
// buffers returns in a skid FIFO and streams them out. Optional zero-latency path: DB_READ_SEQ_BYPASS_EN.
module db_read_sequencer #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_W    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clk_en,
    input  logic               i_flush,
    input  logic [DEPTH_W-1:0] i_depth,
    input  logic               i_start,
    output logic               o_ren_out,
    input  logic [DATA_W-1:0]  i_mem_data,
    input  logic               i_mem_valid,
    output logic [DATA_W-1:0]  o_out_data,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic               o_busy,
    output logic               o_frame_done,
    output logic               o_err_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] LP_FD     = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W:0]   LP_FD_EXT = (CNT_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DEPTH_W-1:0] r_depth_q;
    logic [DEPTH_W-1:0] r_issued;
    logic [DEPTH_W-1:0] r_delivered;
    logic [CNT_W-1:0]   r_inflight;
    logic [CNT_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_rd_ptr;
    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic               r_err;

    logic [CNT_W-1:0]   w_count;
    logic               w_empty;
    logic               w_full;
    logic               w_credit_ok;
    logic               w_start;
    logic               w_ren;
    logic               w_ret_ok;
    logic               w_orphan;
    logic               w_bypass;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_hs;
    logic [DEPTH_W-1:0] w_delivered_nxt;

    // FIFO occupancy from wrap-bit pointers
    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_empty     = (w_count == '0);
    assign w_full      = (w_count == LP_FD);
    assign w_credit_ok = ({1'b0, r_inflight} + {1'b0, w_count}) < LP_FD_EXT;

    assign w_start = i_clk_en && !i_flush && (r_state == S_IDLE) && i_start && (i_depth != '0);

    // A request issued during flush would come back as an orphan, so hold it off.
    assign w_ren = i_clk_en && !i_flush && (r_state == S_READ) &&
                   (r_issued < r_depth_q) && w_credit_ok;

    assign w_ret_ok = i_clk_en && !i_flush && i_mem_valid && (r_inflight != '0);
    assign w_orphan = i_clk_en && i_mem_valid && (r_inflight == '0);

`ifdef DB_READ_SEQ_BYPASS_EN
    assign w_bypass = w_ret_ok && w_empty && i_out_ready;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_pop  = i_clk_en && !i_flush && !w_empty && i_out_ready;
    assign w_push = w_ret_ok && !w_bypass && (!w_full || w_pop);
    assign w_drop = w_ret_ok && !w_bypass && w_full && !w_pop;
    assign w_hs   = w_pop || w_bypass;

    assign w_delivered_nxt = r_delivered + DEPTH_W'(w_hs);

    // Next-state: look at the post-handshake delivered count so frame_done follows the last beat by one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_nxt = S_READ;
            end
            S_READ: begin
                if (r_issued == r_depth_q)
                    w_state_nxt = (w_delivered_nxt == r_depth_q) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if (w_delivered_nxt == r_depth_q) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_flush) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else if (i_clk_en) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_depth_q   <= '0;
            r_issued    <= '0;
            r_delivered <= '0;
            r_inflight  <= '0;
        end else if (i_clk_en) begin
            if (i_flush) begin
                r_issued    <= '0;
                r_delivered <= '0;
                r_inflight  <= '0;
            end else begin
                if (w_start) begin
                    r_depth_q   <= i_depth;
                    r_issued    <= '0;
                    r_delivered <= '0;
                end else begin
                    if (w_ren) r_issued    <= r_issued + DEPTH_W'(1);
                    if (w_hs)  r_delivered <= w_delivered_nxt;
                end
                r_inflight <= r_inflight + CNT_W'(w_ren) - CNT_W'(w_ret_ok);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else if (i_clk_en) begin
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_mem[r_wr_ptr[PTR_W-1:0]] <= i_mem_data;
                    r_wr_ptr <= r_wr_ptr + CNT_W'(1);
                end
                if (w_pop) r_rd_ptr <= r_rd_ptr + CNT_W'(1);
            end
        end
    end

    // Sticky until reset; flush deliberately leaves it alone.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if (w_drop || w_orphan) begin
            r_err <= 1'b1;
        end
    end

    assign o_ren_out      = w_ren;
    assign o_out_valid    = !w_empty || w_bypass;
    assign o_out_data     = w_bypass ? i_mem_data : r_mem[r_rd_ptr[PTR_W-1:0]];
    assign o_busy         = (r_state != S_IDLE);
    assign o_frame_done   = (r_state == S_DONE);
    assign o_err_overflow = r_err;

endmodule

// File: tb/tb_db_read_sequencer.sv
// Directed bench for db_read_sequencer: latency-1 memory model feeds a scoreboard queue of expected words.
module tb_db_read_sequencer;

    localparam int DATA_W     = 16;
    localparam int DEPTH_W    = 16;
    localparam int FIFO_DEPTH = 4;
`ifdef DB_READ_SEQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               clk_en = 1'b1;
    logic               flush = 1'b0;
    logic               start = 1'b0;
    logic               out_ready = 1'b1;
    logic               inj = 1'b0;
    logic [DEPTH_W-1:0] depth = '0;
    logic [DATA_W-1:0]  mem_data;
    logic               mem_valid;
    logic [DATA_W-1:0]  model_data;
    logic               model_valid;

    logic               ren_out;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic               busy;
    logic               frame_done;
    logic               err_overflow;

    db_read_sequencer #(.DATA_W(DATA_W), .DEPTH_W(DEPTH_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en), .i_flush(flush),
        .i_depth(depth), .i_start(start), .o_ren_out(ren_out),
        .i_mem_data(mem_data), .i_mem_valid(mem_valid),
        .o_out_data(out_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_busy(busy), .o_frame_done(frame_done), .o_err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    assign mem_valid = model_valid | inj;
    assign mem_data  = inj ? 16'hDEAD : model_data;

    logic [DATA_W-1:0] exp_q[$];
    int seq = 0;
    int n_assert = 0, n_fail = 0;
    int cyc = 0, ren_cnt = 0, hs_cnt = 0, fd_cnt = 0, fd_cyc = -1, last_hs_cyc = -1;
    logic s_mem_valid = 1'b0, s_out_valid = 1'b0;

    // Memory core: one-cycle read latency, frozen with clk_en like the real core.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_valid <= 1'b0;
            model_data  <= '0;
        end else if (clk_en) begin
            model_valid <= ren_out;
            if (ren_out) begin
                model_data <= 16'hA000 + 16'(seq);
                exp_q.push_back(16'hA000 + 16'(seq));
                seq = seq + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk_cycle();
        @(negedge clk);
        s_mem_valid = mem_valid;
        s_out_valid = out_valid;
        if (ren_out) ren_cnt++;
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (out_valid && out_ready && clk_en && !flush) begin
            hs_cnt++;
            last_hs_cyc = cyc;
            chk("exp_avail", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("data", 32'(out_data), 32'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clr_cnt();
        ren_cnt = 0; hs_cnt = 0; fd_cnt = 0; fd_cyc = -1; last_hs_cyc = -1;
    endtask

    task automatic kick(input int d);
        depth = DEPTH_W'(d);
        start = 1'b1;
        clk_cycle();
        start = 1'b0;
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int n = 0;
        while (fd_cnt == 0 && n < budget) begin
            clk_cycle();
            n++;
        end
        chk({tag, "_done_in_budget"}, 32'(fd_cnt != 0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r0;
        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ren", 32'(ren_out), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_err", 32'(err_overflow), 32'd0);
        rst_n = 1'b1;

        // 1: depth 9 at full throughput
        clr_cnt();
        kick(9);
        run_until_done("t1", 60);
        chk("t1_ren", 32'(ren_cnt), 32'd9);
        chk("t1_words", 32'(hs_cnt), 32'd9);
        chk("t1_done_timing", 32'(fd_cyc), 32'(last_hs_cyc + 1));
        chk("t1_done_pulses", 32'(fd_cnt), 32'd1);
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_fd_after", 32'(frame_done), 32'd0);
        chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // 2: back-pressure holds issue at the credit limit
        clr_cnt();
        out_ready = 1'b0;
        kick(8);
        repeat (12) clk_cycle();
        chk("t2_ren_stalled", 32'(ren_cnt), 32'd4);
        chk("t2_ren_low", 32'(ren_out), 32'd0);
        chk("t2_valid_held", 32'(out_valid), 32'd1);
        chk("t2_head_hold", 32'(out_data), 32'(exp_q[0]));
        out_ready = 1'b1;
        run_until_done("t2", 60);
        chk("t2_ren", 32'(ren_cnt), 32'd8);
        chk("t2_words", 32'(hs_cnt), 32'd8);
        chk("t2_err", 32'(err_overflow), 32'd0);

        // 3: flush mid-frame, then a clean frame
        clr_cnt();
        kick(6);
        n = 0;
        while (ren_cnt < 3 && n < 20) begin
            clk_cycle();
            n++;
        end
        chk("t3_three_issued", 32'(ren_cnt), 32'd3);
        flush = 1'b1;
        clk_cycle();
        flush = 1'b0;
        exp_q.delete();
        chk("t3_idle", 32'(busy), 32'd0);
        chk("t3_out_valid", 32'(out_valid), 32'd0);
        repeat (3) clk_cycle();
        chk("t3_no_done", 32'(fd_cnt), 32'd0);
        chk("t3_no_more_ren", 32'(ren_cnt), 32'd3);
        chk("t3_err", 32'(err_overflow), 32'd0);
        clr_cnt();
        kick(2);
        run_until_done("t3b", 30);
        chk("t3b_ren", 32'(ren_cnt), 32'd2);
        chk("t3b_words", 32'(hs_cnt), 32'd2);

        // 4: zero-depth start, start while busy, clk_en freeze
        clr_cnt();
        kick(0);
        repeat (4) clk_cycle();
        chk("t4_zero_idle", 32'(busy), 32'd0);
        chk("t4_zero_ren", 32'(ren_cnt), 32'd0);
        kick(2);
        depth = 16'd7;
        start = 1'b1;
        clk_cycle();
        start = 1'b0;
        clk_en = 1'b0;
        r0 = ren_cnt;
        repeat (3) clk_cycle();
        chk("t4_frozen_ren", 32'(ren_cnt), 32'(r0));
        chk("t4_frozen_ren_now", 32'(ren_out), 32'd0);
        chk("t4_frozen_busy", 32'(busy), 32'd1);
        clk_en = 1'b1;
        run_until_done("t4", 30);
        chk("t4_ren", 32'(ren_cnt), 32'd2);
        chk("t4_words", 32'(hs_cnt), 32'd2);
        clk_cycle();
        chk("t4_idle_after", 32'(busy), 32'd0);

        // async reset mid-frame, then recovery
        clr_cnt();
        kick(5);
        repeat (2) clk_cycle();
        rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_ren", 32'(ren_out), 32'd0);
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clr_cnt();
        kick(3);
        run_until_done("ar", 30);
        chk("ar_words", 32'(hs_cnt), 32'd3);
        chk("ar_err", 32'(err_overflow), 32'd0);

        // 6: output latency relative to the memory return
        clr_cnt();
        kick(1);
        n = 0;
        while (!s_mem_valid && n < 10) begin
            clk_cycle();
            n++;
        end
        chk("t6_mem_valid_seen", 32'(s_mem_valid), 32'd1);
        chk("t6_valid_same_cycle", 32'(s_out_valid), 32'(BYP));
        clk_cycle();
        chk("t6_valid_next_cycle", 32'(s_out_valid), 32'(!BYP));
        run_until_done("t6", 20);
        chk("t6_words", 32'(hs_cnt), 32'd1);

        // 5: orphan return sets the sticky error and leaves the FIFO alone
        clr_cnt();
        inj = 1'b1;
        clk_cycle();
        inj = 1'b0;
        chk("t5_err_set", 32'(err_overflow), 32'd1);
        chk("t5_fifo_empty", 32'(out_valid), 32'd0);
        repeat (3) clk_cycle();
        chk("t5_err_sticky", 32'(err_overflow), 32'd1);
        kick(3);
        run_until_done("t5", 30);
        chk("t5_words", 32'(hs_cnt), 32'd3);
        chk("t5_err_still", 32'(err_overflow), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_err_cleared", 32'(err_overflow), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
